// File: rtl/timer_pkg.sv
// Shared types and defaults for the down_timer block.
// Optional feature macro: DOWN_TIMER_AUTO_RELOAD_EN (periodic auto-reload).
package timer_pkg;

  // Default counter / load-value width in bits.
  localparam int TIMER_WIDTH_DEF = 4;

  // Timer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

endpackage : timer_pkg

// File: rtl/down_cnt.sv
// Loadable WIDTH-bit down-counter datapath for down_timer.
// Priority: syn_reset > clr > load > dec. Never wraps below zero.
module down_cnt
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             syn_reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: clear, load, or saturating decrement.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (syn_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign is_one = (count_q == WIDTH'(1));

endmodule : down_cnt

// File: rtl/down_timer.sv
// Loadable down-counter / one-shot timer with registered busy and done.
// Optional feature macro: DOWN_TIMER_AUTO_RELOAD_EN -- when defined, the
// timer reloads from the last accepted start value after every done pulse.
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             syn_reset,
  input  logic             ena,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  timer_state_t     state_d, state_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;

  logic             cnt_clr;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_is_one;
  logic [WIDTH-1:0] cnt_count;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_d, reload_q;
`endif

  down_cnt #(
    .WIDTH (WIDTH)
  ) u_down_cnt (
    .clk       (clk),
    .syn_reset (syn_reset),
    .clr       (cnt_clr),
    .load      (cnt_load),
    .load_val  (cnt_load_val),
    .dec       (cnt_dec),
    .count     (cnt_count),
    .is_one    (cnt_is_one)
  );

  // Next-state and datapath control; priority abort > start > ena.
  always_comb begin
    state_d      = state_q;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = load_val;
    cnt_dec      = 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    reload_d     = reload_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Abort in IDLE does nothing, but still blocks a simultaneous start.
        if (start && !abort) begin
          cnt_load = 1'b1;
          state_d  = (load_val != '0) ? RUN : DONE;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
          reload_d = load_val;
`endif
        end
      end

      RUN: begin
        // Start is ignored here: there is no mid-run restart.
        if (abort) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (ena) begin
          cnt_dec = 1'b1;
          if (cnt_is_one) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (abort) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (start) begin
          cnt_load = 1'b1;
          state_d  = (load_val != '0) ? RUN : DONE;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
          reload_d = load_val;
`endif
        end else begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
          // The DONE cycle itself is the first cycle of the next period, so
          // the counter restarts at reload-1 to keep the period at L cycles.
          // Reload values of 0 or 1 therefore give a done every cycle.
          cnt_load = 1'b1;
          if (reload_q > WIDTH'(1)) begin
            cnt_load_val = reload_q - 1'b1;
            state_d      = RUN;
          end else begin
            cnt_load_val = '0;
            state_d      = DONE;
          end
`else
          // Count is already zero on entry to DONE, so it simply holds.
          state_d = IDLE;
`endif
        end
      end

      default: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and registered status outputs.
  always_ff @(posedge clk) begin
    if (syn_reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  // Reload register holding the last accepted start value.
  always_ff @(posedge clk) begin
    if (syn_reset) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign count = cnt_count;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer (WIDTH=4). Expected outputs are pushed
// to a scoreboard queue as each step is driven and popped after the edge.
module tb_down_timer;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    string        tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         syn_reset;
  logic         ena;
  logic         start;
  logic         abort;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  down_timer #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .syn_reset (syn_reset),
    .ena       (ena),
    .start     (start),
    .abort     (abort),
    .load_val  (load_val),
    .count     (count),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, record the expected post-edge outputs, then
  // compare them against the DUT shortly after the rising edge.
  task automatic step(input logic r, input logic s, input logic a,
                      input logic e, input logic [W-1:0] lv,
                      input logic [W-1:0] ec, input logic eb,
                      input logic ed, input string tag);
    exp_t x;
    exp_t got;
    @(negedge clk);
    syn_reset = r;
    start     = s;
    abort     = a;
    ena       = e;
    load_val  = lv;
    x.count = ec;
    x.busy  = eb;
    x.done  = ed;
    x.tag   = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checks++;
    assert (count === got.count) else begin
      errors++;
      $error("FAIL %s count: observed %0d expected %0d", got.tag, count, got.count);
    end
    checks++;
    assert (busy === got.busy) else begin
      errors++;
      $error("FAIL %s busy: observed %b expected %b", got.tag, busy, got.busy);
    end
    checks++;
    assert (done === got.done) else begin
      errors++;
      $error("FAIL %s done: observed %b expected %b", got.tag, done, got.done);
    end
  endtask

  initial begin
    syn_reset = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    ena       = 1'b0;
    load_val  = '0;

    // Reset held for two cycles with start asserted.
    step(1, 1, 0, 1, 4'd5, 4'd0, 0, 0, "reset0");
    step(1, 1, 0, 1, 4'd5, 4'd0, 0, 0, "reset1");
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 0, "idle");

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    // Periodic done every 3 cycles, then abort.
    step(0, 1, 0, 1, 4'd3, 4'd3, 1, 0, "ar_start");
    step(0, 0, 0, 1, 4'd0, 4'd2, 1, 0, "ar_run");
    step(0, 0, 0, 1, 4'd0, 4'd1, 1, 0, "ar_run");
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 1, "ar_done0");
    for (int p = 1; p < 5; p++) begin
      step(0, 0, 0, 1, 4'd0, 4'd2, 1, 0, "ar_reload");
      step(0, 0, 0, 1, 4'd0, 4'd1, 1, 0, "ar_run");
      step(0, 0, 0, 1, 4'd0, 4'd0, 0, 1, "ar_done");
    end
    step(0, 0, 0, 1, 4'd0, 4'd2, 1, 0, "ar_reload");
    step(0, 0, 1, 1, 4'd0, 4'd0, 0, 0, "ar_abort");
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 0, "ar_idle");
`else
    // One-shot L=5; a start mid-run is ignored.
    step(0, 1, 0, 1, 4'd5, 4'd5, 1, 0, "os_start");
    step(0, 0, 0, 1, 4'd0, 4'd4, 1, 0, "os_run4");
    step(0, 0, 0, 1, 4'd0, 4'd3, 1, 0, "os_run3");
    step(0, 1, 0, 1, 4'd9, 4'd2, 1, 0, "os_restart_ignored");
    step(0, 0, 0, 1, 4'd0, 4'd1, 1, 0, "os_run1");
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 1, "os_done");
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 0, "os_idle");

    // Enable gating: ena low for 2 cycles at count=2.
    step(0, 1, 0, 1, 4'd3, 4'd3, 1, 0, "eg_start");
    step(0, 0, 0, 1, 4'd0, 4'd2, 1, 0, "eg_run2");
    step(0, 0, 0, 0, 4'd0, 4'd2, 1, 0, "eg_hold_a");
    step(0, 0, 0, 0, 4'd0, 4'd2, 1, 0, "eg_hold_b");
    step(0, 0, 0, 1, 4'd0, 4'd1, 1, 0, "eg_run1");
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 1, "eg_done");
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 0, "eg_idle");

    // L=0: immediate done, busy never high; back-to-back L=0 starts.
    step(0, 1, 0, 1, 4'd0, 4'd0, 0, 1, "z_done");
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 0, "z_idle");
    step(0, 1, 0, 1, 4'd0, 4'd0, 0, 1, "zz_done0");
    step(0, 1, 0, 1, 4'd0, 4'd0, 0, 1, "zz_done1");
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 0, "zz_idle");

    // L=15: full-range latency, no wrap.
    step(0, 1, 0, 1, 4'd15, 4'd15, 1, 0, "max_start");
    for (int c = 14; c >= 1; c--) begin
      step(0, 0, 0, 1, 4'd0, W'(c), 1, 0, "max_run");
    end
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 1, "max_done");
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 0, "max_idle");
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 0, "max_nowrap");

    // Abort together with start while running at count=4.
    step(0, 1, 0, 1, 4'd6, 4'd6, 1, 0, "ab_start");
    step(0, 0, 0, 1, 4'd0, 4'd5, 1, 0, "ab_run5");
    step(0, 0, 0, 1, 4'd0, 4'd4, 1, 0, "ab_run4");
    step(0, 1, 1, 1, 4'd7, 4'd0, 0, 0, "ab_abort");
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 0, "ab_nodone");

    // Synchronous reset mid-run.
    step(0, 1, 0, 1, 4'd4, 4'd4, 1, 0, "rs_start");
    step(0, 0, 0, 1, 4'd0, 4'd3, 1, 0, "rs_run3");
    step(1, 0, 0, 1, 4'd0, 4'd0, 0, 0, "rs_reset");
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 0, "rs_nodone");

    // Start in the DONE cycle begins a new run.
    step(0, 1, 0, 1, 4'd2, 4'd2, 1, 0, "bb_start");
    step(0, 0, 0, 1, 4'd0, 4'd1, 1, 0, "bb_run1");
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 1, "bb_done0");
    step(0, 1, 0, 1, 4'd3, 4'd3, 1, 0, "bb_restart");
    step(0, 0, 0, 1, 4'd0, 4'd2, 1, 0, "bb_run2");
    step(0, 0, 0, 1, 4'd0, 4'd1, 1, 0, "bb_run1b");
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 1, "bb_done1");
    step(0, 0, 0, 1, 4'd0, 4'd0, 0, 0, "bb_idle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_down_timer
